// File: rtl/cvxif_issue_queue_pkg.sv
// Shared types for the CV-X-IF issue queue: interface structs, table entry,
// FIFO entry, and an elaboration-time parameter legality check.
package cvxif_issue_queue_pkg;

    localparam int unsigned XLen         = 32;
    localparam int unsigned MaxRgprPorts = 3;
    localparam int unsigned HartIdW      = 2;
    localparam int unsigned IdW          = 4;

    typedef enum logic [2:0] {
        ILLEGAL = 3'd0,
        ADD     = 3'd1,
        MUL     = 3'd2,
        MULX    = 3'd3
    } opcode_t;

    typedef logic [HartIdW-1:0] hartid_t;
    typedef logic [IdW-1:0]     id_t;
    typedef logic [MaxRgprPorts-1:0][XLen-1:0] registers_t;

    typedef struct packed {
        logic                    accept;
        logic                    writeback;
        logic [MaxRgprPorts-1:0] register_read;
    } x_issue_resp_t;

    typedef struct packed {
        logic [31:0]   instr;
        logic [31:0]   mask;
        x_issue_resp_t resp;
        opcode_t       opcode;
    } copro_issue_resp_t;

    typedef struct packed {
        logic [31:0] instr;
        hartid_t     hartid;
        id_t         id;
    } x_issue_req_t;

    typedef struct packed {
        registers_t              rs;
        logic [MaxRgprPorts-1:0] rs_valid;
        id_t                     id;
    } x_register_t;

    typedef struct packed {
        opcode_t    opcode;
        hartid_t    hartid;
        id_t        id;
        logic [4:0] rd;
        logic [5:0] imm;
        registers_t registers;
    } fifo_entry_t;

    // Two or three register ports; FIFO depth a power of two, at least 2.
    function automatic bit params_legal(input int unsigned nr, input int unsigned depth);
        return ((nr == 2) || (nr == 3)) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/cvxif_issue_queue_decode_match.sv
// Matches an instruction against the static table; lowest matching index wins.
module cvxif_decode_match
    import cvxif_issue_queue_pkg::*;
#(
    parameter int unsigned NbInstr = 1,
    parameter copro_issue_resp_t [NbInstr-1:0] CoproInstr = '0,
    parameter int unsigned IdxW = 1
) (
    input  logic [31:0]     i_instr,
    output logic            o_hit,
    output logic [IdxW-1:0] o_idx,
    output logic            o_multi
);

    // Priority encoder over the per-entry match bits, flagging extra matches
    always_comb begin
        o_hit   = 1'b0;
        o_idx   = '0;
        o_multi = 1'b0;
        for (int i = 0; i < NbInstr; i++) begin
            if ((CoproInstr[i].mask & i_instr) == CoproInstr[i].instr) begin
                if (o_hit) begin
                    o_multi = 1'b1;
                end else begin
                    o_hit = 1'b1;
                    o_idx = i[IdxW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/cvxif_issue_queue.sv
// CV-X-IF issue stage: decodes offloaded instructions, waits for operands and
// queues accepted instructions in a Depth-entry FIFO toward execution.
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high; valid never depends on ready of the same port.
module cvxif_issue_queue
    import cvxif_issue_queue_pkg::*;
#(
    parameter int unsigned NbInstr = 1,
    parameter copro_issue_resp_t [NbInstr-1:0] CoproInstr = '0,
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          issue_valid_i,
    input  x_issue_req_t  issue_req_i,
    output logic          issue_ready_o,
    output x_issue_resp_t issue_resp_o,
    input  logic          register_valid_i,
    input  x_register_t   register_i,
    input  logic          flush_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output registers_t    out_registers_o,
    output opcode_t       out_opcode_o,
    output hartid_t       out_hartid_o,
    output id_t           out_id_o,
    output logic [4:0]    out_rd_o,
    output logic [5:0]    out_imm_o,
    output logic [CntW-1:0] count_o,
    output logic          multi_match_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned IdxW = (NbInstr > 1) ? $clog2(NbInstr) : 1;
    localparam logic [MaxRgprPorts-1:0] RdMask = MaxRgprPorts'((1 << NrRgprPorts) - 1);

    if (!params_legal(NrRgprPorts, Depth)) begin : g_bad_params
        $error("cvxif_issue_queue: NrRgprPorts must be 2 or 3, Depth a power of two >= 2");
    end

    logic              w_hit;
    logic              w_multi;
    logic [IdxW-1:0]   w_idx;
    copro_issue_resp_t w_entry;
    logic              w_opsok;
    logic              w_pop;
    logic              w_push;
    logic              w_space;
    fifo_entry_t       w_new;
    fifo_entry_t       w_head;
    logic              w_unused;

    fifo_entry_t       r_mem [Depth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;
    logic              r_multi;

    cvxif_decode_match #(
        .NbInstr    (NbInstr),
        .CoproInstr (CoproInstr),
        .IdxW       (IdxW)
    ) u_match (
        .i_instr (issue_req_i.instr),
        .o_hit   (w_hit),
        .o_idx   (w_idx),
        .o_multi (w_multi)
    );

    assign w_entry = CoproInstr[w_idx];

    // Issue response from the winning entry, all zero when idle or unmatched
    always_comb begin
        issue_resp_o = '0;
        if (issue_valid_i && w_hit) begin
            issue_resp_o.accept        = w_entry.resp.accept;
            issue_resp_o.writeback     = w_entry.resp.writeback;
            issue_resp_o.register_read = w_entry.resp.register_read & RdMask;
        end
    end

    // Every requested source port must carry a valid operand for this id
    always_comb begin
        w_opsok = 1'b1;
        for (int j = 0; j < NrRgprPorts; j++) begin
            if (issue_resp_o.register_read[j] &&
                !(register_valid_i && register_i.rs_valid[j] &&
                  (register_i.id == issue_req_i.id))) begin
                w_opsok = 1'b0;
            end
        end
    end

    assign w_pop         = out_valid_o && out_ready_i;
    assign w_space       = (r_count < CntW'(Depth)) || w_pop;
    assign issue_ready_o = issue_resp_o.accept ? (w_opsok && w_space && !flush_i) : 1'b1;
    assign w_push        = issue_valid_i && issue_ready_o && issue_resp_o.accept;

    // Assemble the queued entry; unread register ports are stored as zero
    always_comb begin
        w_new        = '0;
        w_new.opcode = w_entry.opcode;
        w_new.hartid = issue_req_i.hartid;
        w_new.id     = issue_req_i.id;
        w_new.rd     = issue_req_i.instr[11:7];
        w_new.imm    = issue_req_i.instr[31:26];
        for (int j = 0; j < NrRgprPorts; j++) begin
            if (issue_resp_o.register_read[j]) begin
                w_new.registers[j] = register_i.rs[j];
            end
        end
    end

    // FIFO storage, pointers and occupancy; reset, then flush, take priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_new;
                r_wptr        <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for requests that hit more than one table entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_multi <= 1'b0;
        end else if (issue_valid_i && w_multi) begin
            r_multi <= 1'b1;
        end
    end

    assign w_head          = r_mem[r_rptr];
    assign out_valid_o     = (r_count != '0);
    assign out_registers_o = w_head.registers;
    assign out_opcode_o    = w_head.opcode;
    assign out_hartid_o    = w_head.hartid;
    assign out_id_o        = w_head.id;
    assign out_rd_o        = w_head.rd;
    assign out_imm_o       = w_head.imm;
    assign count_o         = r_count;
    assign multi_match_o   = r_multi;

    assign w_unused = ^{register_i.rs, register_i.rs_valid, w_entry.instr, w_entry.mask};

endmodule

// File: tb/tb_cvxif_issue_queue.sv
// Directed bench for cvxif_issue_queue with a scoreboard on the FIFO output.
module tb_cvxif_issue_queue;
    import cvxif_issue_queue_pkg::*;

    localparam int W = 116;

    localparam copro_issue_resp_t E0 = '{instr: 32'h0000_0033, mask: 32'hFE00_707F,
        resp: '{accept: 1'b1, writeback: 1'b1, register_read: 3'b011}, opcode: ADD};
    localparam copro_issue_resp_t E1 = '{instr: 32'h0200_0033, mask: 32'hFE00_707F,
        resp: '{accept: 1'b1, writeback: 1'b1, register_read: 3'b011}, opcode: MUL};
    localparam copro_issue_resp_t E2 = '{instr: 32'h0200_0033, mask: 32'h0200_007F,
        resp: '{accept: 1'b1, writeback: 1'b0, register_read: 3'b111}, opcode: MULX};
    localparam copro_issue_resp_t E3 = '{instr: 32'h0000_000B, mask: 32'h0000_007F,
        resp: '{accept: 1'b0, writeback: 1'b0, register_read: 3'b000}, opcode: ILLEGAL};
    localparam copro_issue_resp_t [3:0] Table = {E3, E2, E1, E0};

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          issue_valid_i = 1'b0;
    x_issue_req_t  issue_req_i = '0;
    logic          issue_ready_o;
    x_issue_resp_t issue_resp_o;
    logic          register_valid_i = 1'b0;
    x_register_t   register_i = '0;
    logic          flush_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    registers_t    out_registers_o;
    opcode_t       out_opcode_o;
    hartid_t       out_hartid_o;
    id_t           out_id_o;
    logic [4:0]    out_rd_o;
    logic [5:0]    out_imm_o;
    logic [2:0]    count_o;
    logic          multi_match_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    cvxif_issue_queue #(
        .NbInstr     (4),
        .CoproInstr  (Table),
        .NrRgprPorts (2),
        .Depth       (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_req_i      (issue_req_i),
        .issue_ready_o    (issue_ready_o),
        .issue_resp_o     (issue_resp_o),
        .register_valid_i (register_valid_i),
        .register_i       (register_i),
        .flush_i          (flush_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_registers_o  (out_registers_o),
        .out_opcode_o     (out_opcode_o),
        .out_hartid_o     (out_hartid_o),
        .out_id_o         (out_id_o),
        .out_rd_o         (out_rd_o),
        .out_imm_o        (out_imm_o),
        .count_o          (count_o),
        .multi_match_o    (multi_match_o)
    );

    // Clock and global time limit
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ent(input opcode_t op, input logic [31:0] instr,
                                         input logic [3:0] id, input logic [31:0] a,
                                         input logic [31:0] b);
        return {op, id[1:0], id, instr[11:7], instr[31:26], 32'h0, b, a};
    endfunction

    function automatic logic [31:0] add_instr(input logic [3:0] id);
        return 32'h0000_0033 | (32'(id) << 7);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rsv, input logic [3:0] rid);
        issue_valid_i       = 1'b1;
        issue_req_i.instr   = instr;
        issue_req_i.hartid  = id[1:0];
        issue_req_i.id      = id;
        register_valid_i    = 1'b1;
        register_i.rs       = {32'h0, b, a};
        register_i.rs_valid = rsv;
        register_i.id       = rid;
        #1;
    endtask

    task automatic idle();
        issue_valid_i    = 1'b0;
        register_valid_i = 1'b0;
    endtask

    // Issue an accepted instruction, waiting a bounded time for ready
    task automatic push_acc(input logic [31:0] instr, input opcode_t op, input logic [3:0] id,
                            input logic [31:0] a, input logic [31:0] b);
        drive(instr, id, a, b, 3'b011, id);
        for (int n = 0; n < 20 && !issue_ready_o; n++) step();
        chk("push_ready", 128'(issue_ready_o), 128'(1));
        chk("push_accept", 128'(issue_resp_o.accept), 128'(1));
        exp_q.push_back(ent(op, instr, id, a, b));
        step();
        idle();
    endtask

    task automatic drain();
        out_ready_i = 1'b1;
        for (int n = 0; n < 20 && count_o != 3'd0; n++) step();
        out_ready_i = 1'b0;
        chk("drain_count", 128'(count_o), 128'(0));
        chk("drain_valid", 128'(out_valid_o), 128'(0));
        chk("drain_queue", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor: compares the head against the scoreboard on every pop
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got id %0h want no entry", out_id_o);
                end else begin
                    chk("head_entry",
                        128'({out_opcode_o, out_hartid_o, out_id_o, out_rd_o, out_imm_o, out_registers_o}),
                        128'(exp_q.pop_front()));
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        chk("rst_count", 128'(count_o), 128'(0));
        chk("rst_valid", 128'(out_valid_o), 128'(0));
        chk("rst_multi", 128'(multi_match_o), 128'(0));
        chk("rst_regs", 128'(out_registers_o), 128'(0));

        // Basic ADD with operands 5 and 7
        drive(add_instr(4'd3), 4'd3, 32'd5, 32'd7, 3'b011, 4'd3);
        chk("add_ready", 128'(issue_ready_o), 128'(1));
        chk("add_accept", 128'(issue_resp_o.accept), 128'(1));
        chk("add_wb", 128'(issue_resp_o.writeback), 128'(1));
        chk("add_rr", 128'(issue_resp_o.register_read), 128'(3'b011));
        exp_q.push_back(ent(ADD, add_instr(4'd3), 4'd3, 32'd5, 32'd7));
        step();
        idle();
        chk("add_count", 128'(count_o), 128'(1));
        chk("add_valid", 128'(out_valid_o), 128'(1));
        chk("add_id", 128'(out_id_o), 128'(3));
        chk("add_regs", 128'(out_registers_o), 128'({32'h0, 32'd7, 32'd5}));
        chk("add_op", 128'(out_opcode_o), 128'(ADD));

        // Unknown instruction and a matched but non-accepted one
        drive(32'h0000_0013, 4'd9, 32'd1, 32'd2, 3'b011, 4'd9);
        chk("unk_ready", 128'(issue_ready_o), 128'(1));
        chk("unk_resp", 128'(issue_resp_o), 128'(0));
        step();
        idle();
        chk("unk_count", 128'(count_o), 128'(1));
        drive(32'h0000_000B, 4'd9, 32'd1, 32'd2, 3'b011, 4'd9);
        chk("noacc_ready", 128'(issue_ready_o), 128'(1));
        chk("noacc_accept", 128'(issue_resp_o.accept), 128'(0));
        step();
        idle();
        chk("noacc_count", 128'(count_o), 128'(1));

        // Fill to Depth; MULX checks truncated register_read and imm
        push_acc(add_instr(4'd4), ADD, 4'd4, 32'h100, 32'h200);
        drive(32'hFE00_12B3, 4'd5, 32'h11, 32'h22, 3'b011, 4'd5);
        chk("mulx_wb", 128'(issue_resp_o.writeback), 128'(0));
        chk("mulx_rr", 128'(issue_resp_o.register_read), 128'(3'b011));
        idle();
        push_acc(32'hFE00_12B3, MULX, 4'd5, 32'h11, 32'h22);
        push_acc(add_instr(4'd6), ADD, 4'd6, 32'h600, 32'h601);
        chk("full_count", 128'(count_o), 128'(4));

        // Fifth sees backpressure until the head pops in the same cycle
        drive(add_instr(4'd7), 4'd7, 32'h700, 32'h701, 3'b011, 4'd7);
        chk("full_ready0", 128'(issue_ready_o), 128'(0));
        step();
        chk("full_ready1", 128'(issue_ready_o), 128'(0));
        chk("full_hold", 128'(count_o), 128'(4));
        out_ready_i = 1'b1;
        #1;
        chk("full_poppush_ready", 128'(issue_ready_o), 128'(1));
        exp_q.push_back(ent(ADD, add_instr(4'd7), 4'd7, 32'h700, 32'h701));
        step();
        idle();
        chk("poppush_count", 128'(count_o), 128'(4));
        drain();

        // Operand waiting: invalid rs[1], then mismatched id
        drive(add_instr(4'd8), 4'd8, 32'd1, 32'd2, 3'b001, 4'd8);
        for (int k = 0; k < 3; k++) begin
            chk("wait_rsv", 128'(issue_ready_o), 128'(0));
            step();
        end
        register_i.rs_valid = 3'b011;
        register_i.id       = 4'd9;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("wait_id", 128'(issue_ready_o), 128'(0));
            step();
        end
        chk("wait_count", 128'(count_o), 128'(0));
        register_i.id = 4'd8;
        #1;
        chk("wait_ready", 128'(issue_ready_o), 128'(1));
        exp_q.push_back(ent(ADD, add_instr(4'd8), 4'd8, 32'd1, 32'd2));
        step();
        idle();
        chk("wait_push", 128'(count_o), 128'(1));

        // Flush with a simultaneous accepted issue
        push_acc(add_instr(4'd10), ADD, 4'd10, 32'ha0, 32'ha1);
        push_acc(add_instr(4'd11), ADD, 4'd11, 32'hb0, 32'hb1);
        chk("preflush_count", 128'(count_o), 128'(3));
        drive(add_instr(4'd12), 4'd12, 32'hc0, 32'hc1, 3'b011, 4'd12);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 128'(issue_ready_o), 128'(0));
        step();
        flush_i = 1'b0;
        idle();
        exp_q.delete();
        chk("flush_count", 128'(count_o), 128'(0));
        chk("flush_valid", 128'(out_valid_o), 128'(0));
        drive(32'h0000_0013, 4'd1, 32'd0, 32'd0, 3'b000, 4'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_noacc_ready", 128'(issue_ready_o), 128'(1));
        step();
        flush_i = 1'b0;
        idle();
        chk("flush2_count", 128'(count_o), 128'(0));

        // Overlapping entries: MUL hits entries 1 and 2, entry 1 wins
        chk("multi_pre", 128'(multi_match_o), 128'(0));
        drive(32'h0200_06B3, 4'd13, 32'h33, 32'h44, 3'b011, 4'd13);
        chk("multi_wb", 128'(issue_resp_o.writeback), 128'(1));
        idle();
        push_acc(32'h0200_06B3, MUL, 4'd13, 32'h33, 32'h44);
        chk("multi_set", 128'(multi_match_o), 128'(1));
        chk("multi_op", 128'(out_opcode_o), 128'(MUL));
        step();
        step();
        chk("multi_sticky", 128'(multi_match_o), 128'(1));
        drain();

        // Reset in the middle of a push
        push_acc(add_instr(4'd14), ADD, 4'd14, 32'he0, 32'he1);
        drive(add_instr(4'd15), 4'd15, 32'hf0, 32'hf1, 3'b011, 4'd15);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_ready", 128'(issue_ready_o), 128'(1));
        step();
        rst_i = 1'b0;
        idle();
        exp_q.delete();
        chk("rst_mid_count", 128'(count_o), 128'(0));
        chk("rst_mid_valid", 128'(out_valid_o), 128'(0));
        chk("rst_mid_multi", 128'(multi_match_o), 128'(0));
        chk("rst_mid_id", 128'(out_id_o), 128'(0));
        chk("rst_mid_regs", 128'(out_registers_o), 128'(0));
        chk("rst_mid_op", 128'(out_opcode_o), 128'(ILLEGAL));
        step();
        chk("end_queue", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
